// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG bit packer slice.
// Holds the byte width, default parameter values and the encoding of the
// drain state machine that feeds the serial transmitter.
package trng_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEPTH_DEF     = 16;
  localparam int RCT_LIMIT_DEF = 32;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/trng_sync_fifo.sv
// Byte-wide synchronous FIFO between the packer and the drain FSM.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (empties FIFO)
//   push_i/push_data_i  write request and byte; accepted if not full, or if
//                       full and a pop happens in the same cycle
//   pop_i            read request; ignored when empty
//   head_o           byte at the read pointer
//   full_o/empty_o   occupancy flags
//   level_o          occupancy, 0..DEPTH
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push_i,
  input  logic [BYTE_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [BYTE_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO still takes a byte when the same edge frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/trng_bit_packer.sv
// Packs raw entropy bits LSB-first into bytes, runs a repetition-count
// health test, buffers bytes in a FIFO and drains them to the serial
// transmitter with a single-cycle write pulse.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_bit, i_bit_valid  raw entropy bit and its qualifier
//   i_com_ready         downstream can accept a byte
//   o_dat, o_write      byte and one-cycle write strobe to downstream
//   o_level             FIFO occupancy
//   o_overflow_cnt      saturating count of bytes dropped on a full FIFO
//   o_health_fail       sticky repetition-count failure
module trng_bit_packer
  import trng_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RCT_LIMIT = RCT_LIMIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_bit,
  input  logic                     i_bit_valid,
  input  logic                     i_com_ready,
  output logic [BYTE_W-1:0]        o_dat,
  output logic                     o_write,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_overflow_cnt,
  output logic                     o_health_fail
);

  localparam logic [7:0] RUN_MAX = 8'(RCT_LIMIT);

  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        run_q, run_d;
  logic              last_q, last_d;
  logic              seen_q, seen_d;
  logic              health_q, health_d;
  logic [CNT_W-1:0]  ovf_q;
  logic              byte_done, push_req;

  drain_state_e      state_q;
  logic [BYTE_W-1:0] dat_q;
  logic              write_q;

  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, pop;

  always_comb begin
    sr_d      = sr_q;
    idx_d     = idx_q;
    run_d     = run_q;
    last_d    = last_q;
    seen_d    = seen_q;
    health_d  = health_q;
    byte_done = 1'b0;
    if (i_bit_valid) begin
      sr_d[idx_q] = i_bit;
      idx_d       = idx_q + 3'd1;
      last_d      = i_bit;
      seen_d      = 1'b1;
      // The first bit after reset has no predecessor, so it starts a run.
      if (!seen_q || (i_bit != last_q)) run_d = 8'd1;
      else if (run_q != RUN_MAX)        run_d = run_q + 8'd1;
      if (run_d == RUN_MAX) health_d = 1'b1;
      byte_done = (idx_q == 3'd7);
    end
  end

  // Using health_d also drops the byte whose last bit trips the test.
  assign push_req = byte_done & ~health_d;
  assign pop      = (state_q == ST_IDLE) & ~fifo_empty & i_com_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sr_q     <= '0;
      idx_q    <= '0;
      run_q    <= '0;
      last_q   <= 1'b0;
      seen_q   <= 1'b0;
      health_q <= 1'b0;
      ovf_q    <= '0;
    end else begin
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      last_q   <= last_d;
      seen_q   <= seen_d;
      health_q <= health_d;
      if (push_req && fifo_full && !pop && !(&ovf_q)) ovf_q <= ovf_q + 1'b1;
    end
  end

  // WAIT always lasts one cycle: it covers a downstream ready that is
  // masked combinationally by the write and sets the 3-cycle spacing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            dat_q   <= fifo_head;
            write_q <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          write_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        default: begin
          write_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  trng_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .push_i      (push_req),
    .push_data_i (sr_d),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (o_level)
  );

  assign o_dat          = dat_q;
  assign o_write        = write_q;
  assign o_overflow_cnt = ovf_q;
  assign o_health_fail  = health_q;

endmodule

// File: tb/tb_trng_bit_packer.sv
module tb_trng_bit_packer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_bit = 1'b0;
  logic        i_bit_valid = 1'b0;
  logic        i_com_ready = 1'b0;

  logic [7:0]  o_dat;
  logic        o_write;
  logic [4:0]  o_level;
  logic [15:0] o_overflow_cnt;
  logic        o_health_fail;

  logic [7:0]  dat4;
  logic        write4;
  logic [4:0]  level4;
  logic [3:0]  ovf4;
  logic        hf4;

  int checks = 0;
  int failures = 0;

  logic [7:0] caps[$];
  int         cap_cyc[$];
  int         cyc = 0;
  int         wide_cnt = 0;
  logic       prev_w = 1'b0;

  always #5 clk = ~clk;

  trng_bit_packer dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_bit          (i_bit),
    .i_bit_valid    (i_bit_valid),
    .i_com_ready    (i_com_ready),
    .o_dat          (o_dat),
    .o_write        (o_write),
    .o_level        (o_level),
    .o_overflow_cnt (o_overflow_cnt),
    .o_health_fail  (o_health_fail)
  );

  trng_bit_packer #(.CNT_W(4)) dut4 (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_bit          (i_bit),
    .i_bit_valid    (i_bit_valid),
    .i_com_ready    (i_com_ready),
    .o_dat          (dat4),
    .o_write        (write4),
    .o_level        (level4),
    .o_overflow_cnt (ovf4),
    .o_health_fail  (hf4)
  );

  // Capture every write pulse of the main instance on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_write) begin
      if (prev_w) wide_cnt = wide_cnt + 1;
      caps.push_back(o_dat);
      cap_cyc.push_back(cyc);
    end
    prev_w = o_write;
  end

  task automatic send_bit(input logic b);
    i_bit = b;
    i_bit_valid = 1'b1;
    @(negedge clk);
    i_bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_caps();
    caps.delete();
    cap_cyc.delete();
  endtask

  task automatic wait_caps(input int n, input int budget);
    int b;
    b = budget;
    while (caps.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (caps.size() != n) begin
      failures++;
      $display("FAIL wait_caps: got %0d writes, expected %0d", caps.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] pat;
    pat = 8'b0000_1101;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #3 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_write, o_dat, o_level, o_overflow_cnt, o_health_fail} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got w=%b d=%h l=%0d o=%0d h=%b, expected all 0",
               o_write, o_dat, o_level, o_overflow_cnt, o_health_fail);
    end
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    clear_caps();
    for (int i = 0; i < 8; i++) send_bit(pat[i]);
    checks++;
    if (o_level !== 5'd1) begin
      failures++;
      $display("FAIL reset_level_after_byte: got %0d expected 1", o_level);
    end
    i_com_ready = 1'b1;
    wait_caps(1, 10);
    checks++;
    if (caps.size() < 1 || caps[0] !== 8'h0D) begin
      failures++;
      $display("FAIL reset_partial_discard: got %h expected 0d", (caps.size() > 0) ? caps[0] : 8'hxx);
    end
  endtask

  task automatic test_pack_drain();
    clear_caps();
    wide_cnt = 0;
    i_com_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h3C);
    wait_caps(2, 30);
    if (caps.size() == 2) begin
      checks++;
      if (caps[0] !== 8'hA5) begin
        failures++;
        $display("FAIL pack_byte0: got %h expected a5", caps[0]);
      end
      checks++;
      if (caps[1] !== 8'h3C) begin
        failures++;
        $display("FAIL pack_byte1: got %h expected 3c", caps[1]);
      end
      checks++;
      if (cap_cyc[1] - cap_cyc[0] < 3) begin
        failures++;
        $display("FAIL pack_spacing: got %0d cycles expected >=3", cap_cyc[1] - cap_cyc[0]);
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      failures++;
      $display("FAIL pack_pulse_width: got %0d long pulses expected 0", wide_cnt);
    end
    checks++;
    if (o_dat !== 8'h3C) begin
      failures++;
      $display("FAIL pack_dat_hold: got %h expected 3c", o_dat);
    end
  endtask

  task automatic test_overflow();
    clear_caps();
    wide_cnt = 0;
    i_com_ready = 1'b0;
    for (int i = 0; i < 18; i++) send_byte((i % 2 == 0) ? 8'h55 : 8'hAA);
    checks++;
    if (o_level !== 5'd16) begin
      failures++;
      $display("FAIL ovf_level: got %0d expected 16", o_level);
    end
    checks++;
    if (o_overflow_cnt !== 16'd2) begin
      failures++;
      $display("FAIL ovf_count: got %0d expected 2", o_overflow_cnt);
    end
    checks++;
    if (caps.size() != 0) begin
      failures++;
      $display("FAIL ovf_write_while_not_ready: got %0d writes expected 0", caps.size());
    end
    i_com_ready = 1'b1;
    wait_caps(16, 80);
    for (int i = 0; i < caps.size() && i < 16; i++) begin
      checks++;
      if (caps[i] !== ((i % 2 == 0) ? 8'h55 : 8'hAA)) begin
        failures++;
        $display("FAIL ovf_drain_order[%0d]: got %h expected %h", i, caps[i],
                 (i % 2 == 0) ? 8'h55 : 8'hAA);
      end
      if (i > 0) begin
        checks++;
        if (cap_cyc[i] - cap_cyc[i-1] < 3) begin
          failures++;
          $display("FAIL ovf_drain_spacing[%0d]: got %0d expected >=3", i, cap_cyc[i] - cap_cyc[i-1]);
        end
      end
    end
    checks++;
    if (o_level !== 5'd0) begin
      failures++;
      $display("FAIL ovf_drained_level: got %0d expected 0", o_level);
    end
    checks++;
    if (wide_cnt !== 0) begin
      failures++;
      $display("FAIL ovf_pulse_width: got %0d long pulses expected 0", wide_cnt);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] nb;
    logic [7:0] exp_b;
    nb = 8'hC3;
    clear_caps();
    i_com_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    checks++;
    if (o_level !== 5'd16) begin
      failures++;
      $display("FAIL ppf_fill_level: got %0d expected 16", o_level);
    end
    for (int i = 0; i < 7; i++) send_bit(nb[i]);
    i_bit = nb[7];
    i_bit_valid = 1'b1;
    i_com_ready = 1'b1;
    @(negedge clk);
    i_bit_valid = 1'b0;
    i_com_ready = 1'b0;
    checks++;
    if (o_write !== 1'b1) begin
      failures++;
      $display("FAIL ppf_pop_issued: got %b expected 1", o_write);
    end
    checks++;
    if (o_level !== 5'd16) begin
      failures++;
      $display("FAIL ppf_level_on_pushpop: got %0d expected 16", o_level);
    end
    checks++;
    if (o_overflow_cnt !== 16'd2) begin
      failures++;
      $display("FAIL ppf_ovf_unchanged: got %0d expected 2", o_overflow_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (o_level !== 5'd16) begin
      failures++;
      $display("FAIL ppf_no_pop_not_ready: got %0d expected 16", o_level);
    end
    i_com_ready = 1'b1;
    wait_caps(17, 90);
    for (int i = 0; i < caps.size() && i < 17; i++) begin
      exp_b = (i < 16) ? (8'h10 + 8'(i)) : 8'hC3;
      checks++;
      if (caps[i] !== exp_b) begin
        failures++;
        $display("FAIL ppf_order[%0d]: got %h expected %h", i, caps[i], exp_b);
      end
    end
    checks++;
    if (o_level !== 5'd0) begin
      failures++;
      $display("FAIL ppf_drained_level: got %0d expected 0", o_level);
    end
  endtask

  task automatic test_ovf_saturation();
    do_reset();
    clear_caps();
    i_com_ready = 1'b0;
    for (int i = 0; i < 36; i++) send_byte((i % 2 == 0) ? 8'h55 : 8'hAA);
    checks++;
    if (ovf4 !== 4'hF) begin
      failures++;
      $display("FAIL sat_cnt4: got %h expected f", ovf4);
    end
    checks++;
    if (o_overflow_cnt !== 16'd20) begin
      failures++;
      $display("FAIL sat_cnt16: got %0d expected 20", o_overflow_cnt);
    end
    checks++;
    if (level4 !== 5'd16) begin
      failures++;
      $display("FAIL sat_level4: got %0d expected 16", level4);
    end
    do_reset();
    checks++;
    if (o_overflow_cnt !== 16'd0 || o_level !== 5'd0) begin
      failures++;
      $display("FAIL sat_reset_clears: got cnt=%0d lvl=%0d expected 0/0", o_overflow_cnt, o_level);
    end
  endtask

  task automatic test_health();
    logic [7:0] exp_h [5];
    exp_h[0] = 8'hAA; exp_h[1] = 8'h55; exp_h[2] = 8'hFF; exp_h[3] = 8'hFF; exp_h[4] = 8'hFF;
    clear_caps();
    i_com_ready = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h55);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    checks++;
    if (o_health_fail !== 1'b0) begin
      failures++;
      $display("FAIL hlt_before_limit: got %b expected 0", o_health_fail);
    end
    checks++;
    if (o_level !== 5'd5) begin
      failures++;
      $display("FAIL hlt_level_pre: got %0d expected 5", o_level);
    end
    send_bit(1'b1);
    checks++;
    if (o_health_fail !== 1'b1) begin
      failures++;
      $display("FAIL hlt_at_limit: got %b expected 1", o_health_fail);
    end
    checks++;
    if (o_level !== 5'd5) begin
      failures++;
      $display("FAIL hlt_trigger_byte_dropped: got %0d expected 5", o_level);
    end
    send_byte(8'h0F);
    send_byte(8'hF0);
    checks++;
    if (o_level !== 5'd5 || o_overflow_cnt !== 16'd0) begin
      failures++;
      $display("FAIL hlt_no_queue: got lvl=%0d ovf=%0d expected 5/0", o_level, o_overflow_cnt);
    end
    i_com_ready = 1'b1;
    wait_caps(5, 40);
    for (int i = 0; i < caps.size() && i < 5; i++) begin
      checks++;
      if (caps[i] !== exp_h[i]) begin
        failures++;
        $display("FAIL hlt_drain[%0d]: got %h expected %h", i, caps[i], exp_h[i]);
      end
    end
    checks++;
    if (o_health_fail !== 1'b1 || o_level !== 5'd0) begin
      failures++;
      $display("FAIL hlt_sticky: got h=%b lvl=%0d expected 1/0", o_health_fail, o_level);
    end
    do_reset();
    checks++;
    if (o_health_fail !== 1'b0) begin
      failures++;
      $display("FAIL hlt_reset_clears: got %b expected 0", o_health_fail);
    end
  endtask

  initial begin
    test_reset();
    test_pack_drain();
    test_overflow();
    test_push_pop_full();
    test_ovf_saturation();
    test_health();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trng_bit_packer.md
Name: trng_bit_packer

Overview:
- Upstream feeder for the serial TRNG transmitter. Takes raw entropy bits from the ring-oscillator sampler and packs them LSB-first into bytes.
- Runs a repetition-count health test on the bit stream and buffers packed bytes in a small synchronous FIFO.
- Drains the FIFO into the transmitter using its i_write/o_ready single-cycle-pulse handshake.
- Lets a stalled link (RTS deasserted, frame overhead) absorb bursts without losing entropy silently.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
- RCT_LIMIT, 32, count of consecutive identical bits that declares a health failure; range 2..255.
- CNT_W, 16, width of the overflow counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_bit  in  1  raw entropy bit.
- i_bit_valid  in  1  i_bit is sampled this cycle; may be asserted every cycle.
- i_com_ready  in  1  downstream can take a byte (transmitter o_ready).
- o_dat  out  8  byte to downstream; valid while o_write=1.
- o_write  out  1  single-cycle write pulse to downstream.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_overflow_cnt  out  CNT_W  count of bytes dropped because the FIFO was full; saturating.
- o_health_fail  out  1  sticky repetition-count failure.

Behaviour:
- Reset (async): packer shift register=0, bit index=0, run length=0, last bit=0, FIFO empty. Outputs: o_write=0, o_dat=0, o_level=0, o_overflow_cnt=0, o_health_fail=0. Reset mid-byte discards the partial byte. Reset mid-drain discards all queued bytes.
- Packing: on each i_bit_valid, the bit is written to position idx (first bit -> bit0) and idx increments mod 8. When idx==7 is written, the complete byte is pushed in that same edge. It appears in the FIFO (o_level+1) the next cycle.
- Health test (repetition count):
  - First valid bit after reset sets run=1.
  - Each later valid bit: equal to the previous bit -> run+1, saturating at RCT_LIMIT; different -> run=1.
  - When run reaches RCT_LIMIT, o_health_fail=1 from the next cycle and stays set until reset.
  - While o_health_fail=1, completed bytes are discarded: no push, no overflow count. Packing continues.
  - The byte whose final bit triggers the failure is also discarded.
  - Bytes already in the FIFO still drain.
- FIFO push: if not full, the byte is stored. If full and a pop happens in the same cycle, the push still succeeds (level unchanged). If full with no pop, the byte is dropped and o_overflow_cnt increments, saturating at all-ones.
- Drain FSM, states IDLE, WRITE, WAIT:
  - IDLE: if FIFO not empty and i_com_ready=1, register o_dat = head, pop, assert o_write=1 -> WRITE.
  - WRITE: o_write=0 -> WAIT. This holds o_write to exactly one cycle.
  - WAIT: go to IDLE when i_com_ready=0 is sampled or one cycle has elapsed. This tolerates the downstream ready being combinationally masked by the write.
  - Minimum spacing between o_write pulses is 3 cycles. o_dat holds its value until the next pop.
  - o_write is never asserted while i_com_ready=0 in the issuing cycle.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally. Level is tracked as a separate counter: +1 on push only, −1 on pop only, unchanged on both. Full = level==DEPTH; empty = level==0.
- Latency: bit→FIFO = 1 cycle after the 8th bit. FIFO→o_write = 1 cycle minimum when ready.

Decomposition:
- Package trng_pkg: BYTE_W=8, default DEPTH/RCT_LIMIT/CNT_W, and the drain-state encoding (IDLE=2'd0, WRITE=2'd1, WAIT=2'd2).
- Sub-module trng_sync_fifo: DEPTH×8 storage, pointers and level, with push/pop/full/empty/level ports.
- Packer, health test, overflow counter and drain FSM live in the top module.

Test Plan:
- Reset: i_reset pulsed asynchronously mid-byte -> all outputs 0; the next 8 bits 1,0,1,1,0,0,0,0 (in order) -> o_dat=8'h0D.
- Packing and drain: bits 8'hA5 LSB-first, then 8'h3C, with i_com_ready=1 -> two o_write pulses carrying 8'hA5 then 8'h3C, ≥3 cycles apart, each one cycle wide.
- Backpressure and overflow: i_com_ready=0, 18 alternating-pattern bytes, DEPTH=16 -> o_level=16, o_overflow_cnt=2. Release ready -> exactly 16 bytes out in order, o_level returns to 0.
- Push with pop when full: full FIFO, i_com_ready=1, a new byte completes on the pop cycle -> o_overflow_cnt unchanged, level stays 16.
- Health failure: 32 consecutive 1s (RCT_LIMIT=32) -> o_health_fail=1 on the cycle after the 32nd bit; further bytes not queued; queued bytes still drain; remains set until reset.
- Overflow saturation: CNT_W=4 override, 20 dropped bytes -> o_overflow_cnt=4'hF.
